// File: rtl/uart_pkg.sv
// Shared definitions for the UART core: parity modes, engine state encodings
// and the parity helper used by both the transmit and receive engines.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_PARITY    = 3'd3,
        RX_STOP      = 3'd4,
        RX_WAIT_IDLE = 3'd5
    } rx_state_t;

    // Payload is zero-extended to 9 bits so every legal width shares one helper.
    function automatic logic calc_parity(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_if.sv
// Fabric-side bundle of the UART: transmit handshake and receive result signals.
interface uart_if #(parameter int DATA_BITS = 8);
    logic                 start;
    logic [DATA_BITS-1:0] tx_data;
    logic                 busy;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_error;
    logic                 parity_error;

    modport master  (output start, tx_data,
                     input  busy, rx_data, rx_valid, rx_error, parity_error);
    modport slave   (input  start, tx_data,
                     output busy, rx_data, rx_valid, rx_error, parity_error);
    modport tx_side (input  start, tx_data, output busy);
    modport rx_side (output rx_data, rx_valid, rx_error, parity_error);
endinterface

// File: rtl/uart_rx_engine.sv
// UART receiver: 2-flop synchroniser, start-bit glitch filter, mid-bit sampling,
// parity and framing checks with framing taking precedence.
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0
) (
    input  logic   clk_i,
    input  logic   reset_i,
    input  logic   serial_i,
    uart_if.rx_side bus
);

    localparam int            CW       = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BAUD_ONE = CW'(1);
    localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);
    localparam logic          ODD      = (PARITY == PARITY_ODD);
    localparam logic          HAS_PAR  = (PARITY != PARITY_NONE);

    logic                 sync1_q, sync2_q;
    rx_state_t            state_q, state_d;
    logic [CW-1:0]        baud_q, baud_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_ok_q, par_ok_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic                 perr_q, perr_d;
    logic                 rx_s;

    assign rx_s = sync2_q;

    // Next-state logic; the stop sample resolves the frame and returns to IDLE
    // half a bit early so back-to-back frames are caught.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_ok_d = par_ok_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        perr_d   = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    state_d = RX_START;
                    baud_d  = '0;
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (baud_q == HALF_END) begin
                    baud_d = '0;
                    bit_d  = 4'd0;
                    if (rx_s) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d = RX_DATA;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            RX_DATA: begin
                if (baud_q == BIT_END) begin
                    baud_d  = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (bit_q == LAST_BIT) begin
                        par_ok_d = 1'b1;
                        state_d  = HAS_PAR ? RX_PARITY : RX_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            RX_PARITY: begin
                if (baud_q == BIT_END) begin
                    baud_d   = '0;
                    par_ok_d = (rx_s == calc_parity(9'(shift_q), ODD));
                    state_d  = RX_STOP;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            RX_STOP: begin
                if (baud_q == BIT_END) begin
                    baud_d = '0;
                    data_d = shift_q;
                    if (!rx_s) begin
                        err_d   = 1'b1;
                        state_d = RX_WAIT_IDLE;
                    end else if (!par_ok_q) begin
                        err_d   = 1'b1;
                        perr_d  = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        valid_d = 1'b1;
                        state_d = RX_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            RX_WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = RX_IDLE;
                end else begin
                    state_d = RX_WAIT_IDLE;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    // Synchroniser, state and result registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            state_q  <= RX_IDLE;
            baud_q   <= '0;
            bit_q    <= 4'd0;
            shift_q  <= '0;
            par_ok_q <= 1'b1;
            data_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            sync1_q  <= serial_i;
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_ok_q <= par_ok_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            perr_q   <= perr_d;
        end
    end

    assign bus.rx_data      = data_q;
    assign bus.rx_valid     = valid_q;
    assign bus.rx_error     = err_q;
    assign bus.parity_error = perr_q;

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: start bit, LSB-first payload, optional parity, stop bit(s).
// serial_o and busy are registered so the line never glitches.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic   clk_i,
    input  logic   reset_i,
    uart_if.tx_side bus,
    output logic   serial_o
);

    localparam int              CW       = $clog2(2 * CLKS_PER_BIT + 1);
    localparam logic [CW-1:0]   BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   STOP_END = CW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   BAUD_ONE = CW'(1);
    localparam logic [3:0]      LAST_BIT = 4'(DATA_BITS - 1);
    localparam logic            ODD      = (PARITY == PARITY_ODD);
    localparam logic            HAS_PAR  = (PARITY != PARITY_NONE);

    tx_state_t            state_q, state_d;
    logic [CW-1:0]        baud_q, baud_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;

    // Next-state logic: each state lasts one bit period, STOP lasts STOP_BITS periods.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        case (state_q)
            TX_IDLE: begin
                if (bus.start) begin
                    state_d = TX_START;
                    baud_d  = '0;
                    bit_d   = 4'd0;
                    shift_d = bus.tx_data;
                    par_d   = calc_parity(9'(bus.tx_data), ODD);
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    tx_d   = 1'b1;
                    busy_d = 1'b0;
                end
            end
            TX_START: begin
                if (baud_q == BIT_END) begin
                    state_d = TX_DATA;
                    baud_d  = '0;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            TX_DATA: begin
                if (baud_q == BIT_END) begin
                    baud_d = '0;
                    if (bit_q == LAST_BIT) begin
                        if (HAS_PAR) begin
                            state_d = TX_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = TX_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            TX_PARITY: begin
                if (baud_q == BIT_END) begin
                    state_d = TX_STOP;
                    baud_d  = '0;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            TX_STOP: begin
                if (baud_q == STOP_END) begin
                    state_d = TX_IDLE;
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            default: begin
                state_d = TX_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= TX_IDLE;
            baud_q  <= '0;
            bit_q   <= 4'd0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign serial_o = tx_q;
    assign bus.busy = busy_q;

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART top: fabric pins are gathered onto an internal bundle that
// the independent transmit and receive engines attach to.
module uart_core #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_busy,
    output logic                 serial_out,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] received_data,
    output logic                 data_is_valid,
    output logic                 rx_error,
    output logic                 parity_error
);

    uart_if #(.DATA_BITS(DATA_BITS)) u_bus ();

    assign u_bus.start    = start;
    assign u_bus.tx_data  = i_data;
    assign o_busy         = u_bus.busy;
    assign received_data  = u_bus.rx_data;
    assign data_is_valid  = u_bus.rx_valid;
    assign rx_error       = u_bus.rx_error;
    assign parity_error   = u_bus.parity_error;

    uart_tx_engine #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .DATA_BITS   (DATA_BITS),
        .PARITY      (PARITY),
        .STOP_BITS   (STOP_BITS)
    ) u_tx (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (u_bus.tx_side),
        .serial_o(serial_out)
    );

    uart_rx_engine #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .DATA_BITS   (DATA_BITS),
        .PARITY      (PARITY)
    ) u_rx (
        .clk_i   (clk),
        .reset_i (reset),
        .serial_i(serial_in),
        .bus     (u_bus.rx_side)
    );

endmodule

// File: tb/tb_uart_core.sv
// Bench for uart_core: an 8N1 instance and an 8E2 instance, checked against a
// frame-level model (bit lists) and a queue of observed receive events.
module tb_uart_core;

    localparam int CPB = 8;
    localparam int DB  = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_if #(.DATA_BITS(DB)) bus0 ();
    uart_if #(.DATA_BITS(DB)) bus2 ();

    logic line0 = 1'b1, line2 = 1'b1, loop0 = 1'b0, loop2 = 1'b0;
    logic so0, so2, si0, si2;
    assign si0 = loop0 ? so0 : line0;
    assign si2 = loop2 ? so2 : line2;

    uart_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset(reset), .start(bus0.start), .i_data(bus0.tx_data),
        .o_busy(bus0.busy), .serial_out(so0), .serial_in(si0),
        .received_data(bus0.rx_data), .data_is_valid(bus0.rx_valid),
        .rx_error(bus0.rx_error), .parity_error(bus0.parity_error));

    uart_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(2), .STOP_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .start(bus2.start), .i_data(bus2.tx_data),
        .o_busy(bus2.busy), .serial_out(so2), .serial_in(si2),
        .received_data(bus2.rx_data), .data_is_valid(bus2.rx_valid),
        .rx_error(bus2.rx_error), .parity_error(bus2.parity_error));

    int checks = 0;
    int errors = 0;

    // Receive events: {rx_error, parity_error, data_is_valid, received_data}
    logic [10:0] q0[$];
    logic [10:0] q2[$];

    always @(negedge clk) begin
        if (!reset) begin
            if (bus0.rx_valid || bus0.rx_error || bus0.parity_error)
                q0.push_back({bus0.rx_error, bus0.parity_error, bus0.rx_valid, bus0.rx_data});
            if (bus2.rx_valid || bus2.rx_error || bus2.parity_error)
                q2.push_back({bus2.rx_error, bus2.parity_error, bus2.rx_valid, bus2.rx_data});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Frame as a list of line levels, first bit in bits[0].
    function automatic void frame_bits(input logic [7:0] d, input int par, input int stops,
                                       input bit bad_par, input bit bad_stop,
                                       output logic [15:0] bits, output int n);
        int  ones;
        logic p;
        ones = $countones(d);
        bits = '0;
        n    = 0;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < 8; i++) begin bits[n] = d[i]; n++; end
        if (par != 0) begin
            p = (par == 2) ? ((ones % 2) == 1) : ((ones % 2) == 0);
            bits[n] = p ^ bad_par; n++;
        end
        for (int s = 0; s < stops; s++) begin
            bits[n] = !(bad_stop && (s == 0)); n++;
        end
    endfunction

    task automatic set_start(input int sel, input logic s, input logic [7:0] d);
        if (sel == 0) begin bus0.start = s; bus0.tx_data = d; end
        else          begin bus2.start = s; bus2.tx_data = d; end
    endtask

    task automatic set_line(input int sel, input logic v);
        if (sel == 0) line0 = v; else line2 = v;
    endtask

    function automatic logic get_so(input int sel);
        return (sel == 0) ? so0 : so2;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? bus0.busy : bus2.busy;
    endfunction

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Called at a negedge with o_busy low; checks every cycle of the frame.
    task automatic tx_frame(input int sel, input logic [7:0] d, input int inject_at);
        logic [15:0] bits;
        int n;
        frame_bits(d, (sel == 0) ? 0 : 2, (sel == 0) ? 1 : 2, 1'b0, 1'b0, bits, n);
        set_start(sel, 1'b1, d);
        for (int c = 0; c < n * CPB; c++) begin
            @(negedge clk);
            if (c == inject_at) set_start(sel, 1'b1, ~d);
            else                set_start(sel, 1'b0, d);
            chk($sformatf("tx%0d_%02h_bit%0d", sel, d, c / CPB), get_so(sel), bits[c / CPB]);
            chk($sformatf("tx%0d_%02h_busy_c%0d", sel, d, c), get_busy(sel), 1'b1);
        end
        @(negedge clk);
        set_start(sel, 1'b0, d);
        chk($sformatf("tx%0d_%02h_busy_end", sel, d), get_busy(sel), 1'b0);
        chk($sformatf("tx%0d_%02h_idle_line", sel, d), get_so(sel), 1'b1);
    endtask

    task automatic drive_frame(input int sel, input logic [7:0] d, input bit bad_par, input bit bad_stop);
        logic [15:0] bits;
        int n;
        frame_bits(d, (sel == 0) ? 0 : 2, 1, bad_par, bad_stop, bits, n);
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                set_line(sel, bits[b]);
            end
        end
    endtask

    task automatic expect_ev(input int sel, input logic [2:0] kind, input logic [7:0] d, input string tag);
        logic [10:0] e;
        int sz;
        sz = (sel == 0) ? q0.size() : q2.size();
        chk({tag, "_present"}, (sz > 0), 1'b1);
        if (sz > 0) begin
            e = (sel == 0) ? q0.pop_front() : q2.pop_front();
            chk({tag, "_kind"}, e[10:8], kind);
            chk({tag, "_data"}, e[7:0], d);
        end
    endtask

    task automatic expect_none(input int sel, input string tag);
        chk({tag, "_no_extra_events"}, (sel == 0) ? q0.size() : q2.size(), 0);
        if (sel == 0) q0.delete(); else q2.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d;
        bit bp, bs;
        logic [2:0] k;
        bus0.start = 1'b0; bus0.tx_data = 8'h00;
        bus2.start = 1'b0; bus2.tx_data = 8'h00;

        // Reset state
        wait_cycles(3);
        chk("rst_so0", so0, 1'b1);             chk("rst_so2", so2, 1'b1);
        chk("rst_busy0", bus0.busy, 1'b0);     chk("rst_busy2", bus2.busy, 1'b0);
        chk("rst_data0", bus0.rx_data, 8'h00); chk("rst_data2", bus2.rx_data, 8'h00);
        chk("rst_pulses0", {bus0.rx_valid, bus0.rx_error, bus0.parity_error}, 3'b000);
        chk("rst_pulses2", {bus2.rx_valid, bus2.rx_error, bus2.parity_error}, 3'b000);
        reset = 1'b0;
        wait_cycles(2);

        // 8N1 transmit waveform of 0xA5, busy exactly 80 cycles
        tx_frame(0, 8'hA5, -1);
        wait_cycles(5);
        expect_none(0, "a5_no_rx");

        // 8E2 loopback, back-to-back, with an ignored start mid-frame
        loop2 = 1'b1;
        tx_frame(2, 8'h3C, 20);
        tx_frame(2, 8'hFF, -1);
        wait_cycles(10);
        expect_ev(2, 3'b001, 8'h3C, "loop_3c");
        expect_ev(2, 3'b001, 8'hFF, "loop_ff");
        expect_none(2, "loop");
        loop2 = 1'b0;
        wait_cycles(4);

        // Parity error: 0x01 with parity bit 0
        drive_frame(2, 8'h01, 1'b1, 1'b0);
        wait_cycles(10);
        expect_ev(2, 3'b110, 8'h01, "par_err");
        expect_none(2, "par_err");
        chk("par_err_rx_data_held", bus2.rx_data, 8'h01);

        // Framing error followed by a break, then a clean frame
        drive_frame(0, 8'h55, 1'b0, 1'b1);
        wait_cycles(40);
        line0 = 1'b1;
        wait_cycles(10);
        expect_ev(0, 3'b100, 8'h55, "framing");
        expect_none(0, "framing");
        drive_frame(0, 8'h55, 1'b0, 1'b0);
        wait_cycles(10);
        expect_ev(0, 3'b001, 8'h55, "after_break");
        expect_none(0, "after_break");

        // 3-cycle glitch, then 0x81
        line0 = 1'b0;
        wait_cycles(3);
        line0 = 1'b1;
        wait_cycles(20);
        expect_none(0, "glitch");
        drive_frame(0, 8'h81, 1'b0, 1'b0);
        wait_cycles(10);
        expect_ev(0, 3'b001, 8'h81, "post_glitch");
        expect_none(0, "post_glitch");

        // Reset during bit 3 of a looped-back transmit
        loop0 = 1'b1;
        set_start(0, 1'b1, 8'h42);
        @(negedge clk);
        set_start(0, 1'b0, 8'h42);
        wait_cycles(4 * CPB + 2);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_so", so0, 1'b1);
        chk("midrst_busy", bus0.busy, 1'b0);
        chk("midrst_data", bus0.rx_data, 8'h00);
        reset = 1'b0;
        wait_cycles(100);
        expect_none(0, "midrst");
        expect_none(2, "midrst2");
        tx_frame(0, 8'h42, -1);
        wait_cycles(10);
        expect_ev(0, 3'b001, 8'h42, "rt_42");
        expect_none(0, "rt_42");

        // Random loopback round trips on both instances
        loop2 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom_range(0, 255));
            tx_frame(i % 2 == 0 ? 0 : 2, d, -1);
            wait_cycles(10);
            expect_ev(i % 2 == 0 ? 0 : 2, 3'b001, d, $sformatf("rand_loop%0d", i));
        end
        loop0 = 1'b0;
        loop2 = 1'b0;
        wait_cycles(4);

        // Random driven frames with random parity and stop faults
        for (int i = 0; i < 8; i++) begin
            d  = 8'($urandom_range(0, 255));
            bp = 1'($urandom_range(0, 1));
            bs = 1'($urandom_range(0, 1));
            drive_frame(2, d, bp, bs);
            line2 = 1'b1;
            wait_cycles(12);
            k = bs ? 3'b100 : (bp ? 3'b110 : 3'b001);
            expect_ev(2, k, d, $sformatf("rand_rx%0d", i));
        end
        expect_none(2, "rand_rx");
        expect_none(0, "final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
